issue_execute_fifo: RTL and testbench
=====================================

ISSUE_EXECUTE_FIFO -- requirements
Module: issue_execute_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..16.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; SHALL be asynchronous and active-low (0 = in reset).
REQ-004 issue_execute_fifo_data_in  in  issue_execute_pack_t  entry written by issue stage.
REQ-005 issue_execute_fifo_push  in  1  write request from issue stage.
REQ-006 issue_execute_fifo_full  out  1  no free entry; push SHALL be ignored while high.
REQ-007 issue_execute_fifo_data_out  out  issue_execute_pack_t  head entry, show-ahead, read by execute unit.
REQ-008 issue_execute_fifo_data_out_valid  out  1  data_out holds a live entry.
REQ-009 issue_execute_fifo_pop  in  1  execute unit consumes head entry.
REQ-010 issue_execute_fifo_flush  in  1  discard all entries (commit flush).
REQ-011 issue_execute_fifo_count  out  $clog2(DEPTH)+1  registered occupancy.

Function
REQ-012 Storage SHALL be DEPTH registers indexed by rd_ptr/wr_ptr of $clog2(DEPTH)+1 bits; MSB is the wrap bit.
REQ-013 empty SHALL equal (rd_ptr == wr_ptr); full SHALL equal index bits equal and wrap bits different.
REQ-014 count SHALL equal wr_ptr - rd_ptr (modulo 2^(ptr width)), range 0..DEPTH.
REQ-015 Push accepted when push && !full && !flush; entry written at wr_ptr, wr_ptr += 1 at the next edge.
REQ-016 Pop accepted when pop && data_out_valid && !flush; rd_ptr += 1 at the next edge.
REQ-017 Pop while data_out_valid = 0 SHALL change no state.
REQ-018 Push while full SHALL change no state, including when a pop is accepted the same cycle (no pass-through when full).
REQ-019 Simultaneous accepted push and pop SHALL leave count unchanged and move both pointers.
REQ-020 Pointer wrap (index DEPTH-1 -> 0) SHALL toggle the wrap bit; order SHALL be preserved across the wrap.
REQ-021 data_out SHALL be combinational from the entry at rd_ptr; data_out_valid = !empty (see REQ-027 for bypass).
REQ-022 Flush SHALL set rd_ptr = wr_ptr = 0 at the next edge and take priority over push and pop in the same cycle.
REQ-023 Stored payload SHALL NOT be cleared by flush or reset; only the pointers move.
REQ-024 Latency: an entry pushed in cycle N SHALL be visible on data_out with valid = 1 in cycle N+1 (bypass disabled).

Reset
REQ-025 While rst = 0: rd_ptr = wr_ptr = 0, full = 0, data_out_valid = 0, count = 0, asynchronously and without waiting for a clock edge.
REQ-026 If reset asserts mid-operation, all entries SHALL be discarded; the first push after release SHALL appear at head.

Configuration
REQ-027 With ISSUE_EXECUTE_FIFO_BYPASS_EN defined: when empty and push && !flush, data_out SHALL equal data_in and data_out_valid = 1 in the same cycle.
REQ-028 With the macro, a same-cycle pop of a bypassed entry SHALL consume it: no write, pointers unchanged.
REQ-029 With the macro, a bypassed entry that is not popped SHALL be stored as in REQ-015.
REQ-030 Without the macro, the output SHALL depend only on stored state (REQ-021, REQ-024); data_in never reaches data_out combinationally.

Verification
REQ-031 Reset, then push rob_id 1,2,3,4 on consecutive cycles, pop = 0 -> full = 1 after the 4th edge, count = 4, head rob_id = 1.
REQ-032 Full FIFO: push rob_id 9 with pop = 1 -> head advances to rob_id 2, count = 3, rob_id 9 never appears.
REQ-033 Run 10 push+pop pairs with rob_id 10..19 from count = 1 -> count stays 1, output order is exact across two pointer wraps.
REQ-034 Count = 3 with flush = 1, push = 1 and pop = 1 -> next cycle count = 0, valid = 0; the next push appears at head.
REQ-035 Push 3 entries, assert rst = 0 between clock edges -> valid = 0 and count = 0 immediately; after release, push rob_id 5 -> head rob_id = 5.
REQ-036 Empty FIFO, push rob_id 7 with pop = 1 -> bypass build: data_out rob_id = 7, valid = 1 that cycle, count stays 0; non-bypass build: valid = 0 that cycle, count = 1 next cycle.

Source files
------------

// File: rtl/issue_execute_fifo.sv
// Issue-to-execute queue: DEPTH-entry show-ahead FIFO with wrap-bit pointers and commit flush.
// Optional same-cycle empty bypass when ISSUE_EXECUTE_FIFO_BYPASS_EN is defined.

package issue_execute_pkg;
  typedef struct packed {
    logic [4:0]  rob_id;
    logic [6:0]  opcode;
    logic [4:0]  dest_reg;
    logic [31:0] src_a;
    logic [31:0] src_b;
  } issue_execute_pack_t;
endpackage

module issue_execute_fifo
  import issue_execute_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  issue_execute_pack_t        issue_execute_fifo_data_in,
  input  logic                       issue_execute_fifo_push,
  output logic                       issue_execute_fifo_full,
  output issue_execute_pack_t        issue_execute_fifo_data_out,
  output logic                       issue_execute_fifo_data_out_valid,
  input  logic                       issue_execute_fifo_pop,
  input  logic                       issue_execute_fifo_flush,
  output logic [$clog2(DEPTH):0]     issue_execute_fifo_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  issue_execute_pack_t mem_r [DEPTH];

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] count_r;
  logic             full_r;

  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] count_nxt_s;
  logic             full_nxt_s;
  logic             empty_s;
  logic             bypass_s;
  logic             valid_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             consume_s;
  logic             wr_en_s;
  issue_execute_pack_t head_s;

  // Head selection: stored entry, or the incoming entry when bypassing an empty queue
  always_comb begin
    empty_s = (rd_ptr_r == wr_ptr_r);
    head_s  = mem_r[rd_ptr_r[IDX_W-1:0]];
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    bypass_s = empty_s && issue_execute_fifo_push && !issue_execute_fifo_flush;
    if (bypass_s) begin
      head_s = issue_execute_fifo_data_in;
    end else begin
      head_s = mem_r[rd_ptr_r[IDX_W-1:0]];
    end
`else
    bypass_s = 1'b0;
`endif
    valid_s = !empty_s || bypass_s;
  end

  // Accept logic and next-state pointer computation; flush overrides push and pop
  always_comb begin
    push_ok_s    = issue_execute_fifo_push && !full_r && !issue_execute_fifo_flush;
    pop_ok_s     = issue_execute_fifo_pop && valid_s && !issue_execute_fifo_flush;
    // A bypassed entry popped in the same cycle never touches storage
    consume_s    = bypass_s && pop_ok_s;
    wr_en_s      = 1'b0;
    rd_ptr_nxt_s = rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    if (issue_execute_fifo_flush) begin
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      if (pop_ok_s && !consume_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      if (push_ok_s && !consume_s) begin
        wr_en_s      = 1'b1;
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_en_s      = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
      end
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s  = (wr_ptr_nxt_s[IDX_W-1:0] == rd_ptr_nxt_s[IDX_W-1:0]) &&
                  (wr_ptr_nxt_s[IDX_W] != rd_ptr_nxt_s[IDX_W]);
  end

  // Pointer and status registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {PTR_W{1'b0}};
      full_r   <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
    end
  end

  // Payload storage; deliberately not reset so flush/reset only move pointers
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[IDX_W-1:0]] <= issue_execute_fifo_data_in;
    end
  end

  assign issue_execute_fifo_full           = full_r;
  assign issue_execute_fifo_count          = count_r;
  assign issue_execute_fifo_data_out       = head_s;
  assign issue_execute_fifo_data_out_valid = valid_s;

endmodule

// File: tb/tb_issue_execute_fifo.sv
// Directed bench for issue_execute_fifo (DEPTH = 4); checks via immediate assertions.
module tb_issue_execute_fifo;
  import issue_execute_pkg::*;

  logic                clk;
  logic                rst;
  issue_execute_pack_t data_in;
  logic                push;
  logic                full;
  issue_execute_pack_t data_out;
  logic                data_out_valid;
  logic                pop;
  logic                flush;
  logic [2:0]          count;

  int total;
  int bad;

  issue_execute_fifo #(.DEPTH(4)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .issue_execute_fifo_data_in       (data_in),
    .issue_execute_fifo_push          (push),
    .issue_execute_fifo_full          (full),
    .issue_execute_fifo_data_out      (data_out),
    .issue_execute_fifo_data_out_valid(data_out_valid),
    .issue_execute_fifo_pop           (pop),
    .issue_execute_fifo_flush         (flush),
    .issue_execute_fifo_count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_execute_pack_t mk(input int rob);
    issue_execute_pack_t p;
    p.rob_id   = 5'(rob);
    p.opcode   = 7'(rob * 3 + 1);
    p.dest_reg = 5'(rob + 2);
    p.src_a    = 32'hA000_0000 + 32'(rob);
    p.src_b    = 32'h0B00_0000 + 32'(rob * 5);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; data_in = mk(0);
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 128'(data_out_valid), 128'(1'b0));
    chk("rst_count", 128'(count), 128'(3'd0));
    chk("rst_full",  128'(full), 128'(1'b0));
    step();
    rst = 1'b1;

    // fill 1..4, latency one cycle
    push = 1'b1; data_in = mk(1);
    step();
    chk("lat_valid", 128'(data_out_valid), 128'(1'b1));
    chk("lat_head",  128'(data_out), 128'(mk(1)));
    chk("lat_count", 128'(count), 128'(3'd1));
    data_in = mk(2); step();
    data_in = mk(3); step();
    data_in = mk(4); step();
    chk("fill_full",  128'(full), 128'(1'b1));
    chk("fill_count", 128'(count), 128'(3'd4));
    chk("fill_head",  128'(data_out), 128'(mk(1)));

    // push while full with pop: pop only
    data_in = mk(9); pop = 1'b1;
    step();
    chk("fullpp_head",  128'(data_out), 128'(mk(2)));
    chk("fullpp_count", 128'(count), 128'(3'd3));
    chk("fullpp_full",  128'(full), 128'(1'b0));
    push = 1'b0;
    step();
    chk("pop_head3", 128'(data_out), 128'(mk(3)));
    step();
    chk("pop_head4", 128'(data_out), 128'(mk(4)));
    chk("pop_count1", 128'(count), 128'(3'd1));

    // 10 push+pop pairs across pointer wraps
    push = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = mk(10 + i);
      step();
      chk($sformatf("pair%0d_head", i), 128'(data_out), 128'(mk(10 + i)));
      chk($sformatf("pair%0d_count", i), 128'(count), 128'(3'd1));
    end
    pop = 1'b0;
    data_in = mk(20); step();
    data_in = mk(21); step();
    chk("pre_flush_count", 128'(count), 128'(3'd3));

    // flush beats push and pop
    flush = 1'b1; pop = 1'b1; data_in = mk(22);
    step();
    chk("flush_count", 128'(count), 128'(3'd0));
    chk("flush_valid", 128'(data_out_valid), 128'(1'b0));
    flush = 1'b0; pop = 1'b0; data_in = mk(23);
    step();
    chk("postflush_head",  128'(data_out), 128'(mk(23)));
    chk("postflush_count", 128'(count), 128'(3'd1));
    push = 1'b0; pop = 1'b1;
    step();
    chk("drain_valid", 128'(data_out_valid), 128'(1'b0));
    // pop on empty changes nothing
    step();
    chk("emptypop_count", 128'(count), 128'(3'd0));
    chk("emptypop_full",  128'(full), 128'(1'b0));
    pop = 1'b0;

    // reset mid-operation, between edges
    push = 1'b1;
    data_in = mk(25); step();
    data_in = mk(26); step();
    data_in = mk(27); step();
    chk("prerst_count", 128'(count), 128'(3'd3));
    push = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midrst_valid", 128'(data_out_valid), 128'(1'b0));
    chk("midrst_count", 128'(count), 128'(3'd0));
    rst = 1'b1;
    step();
    chk("postrst_count", 128'(count), 128'(3'd0));
    push = 1'b1; data_in = mk(5);
    step();
    chk("postrst_head", 128'(data_out), 128'(mk(5)));
    push = 1'b0; pop = 1'b1;
    step();
    chk("postrst_drain", 128'(count), 128'(3'd0));

    // empty push+pop: bypass vs. stored
    push = 1'b1; pop = 1'b1; data_in = mk(7);
    #1;
`ifdef ISSUE_EXECUTE_FIFO_BYPASS_EN
    chk("byp_valid", 128'(data_out_valid), 128'(1'b1));
    chk("byp_head",  128'(data_out), 128'(mk(7)));
    step();
    chk("byp_count", 128'(count), 128'(3'd0));
`else
    chk("nobyp_valid", 128'(data_out_valid), 128'(1'b0));
    step();
    chk("nobyp_count", 128'(count), 128'(3'd1));
    chk("nobyp_head",  128'(data_out), 128'(mk(7)));
`endif
    push = 1'b0; pop = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;

    // full without pop drops the push; drain in order
    push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = mk(30 + i);
      step();
    end
    push = 1'b0;
    chk("full_drop_count", 128'(count), 128'(3'd4));
    chk("full_drop_full",  128'(full), 128'(1'b1));
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_head", i), 128'(data_out), 128'(mk(30 + i)));
      step();
    end
    pop = 1'b0;
    chk("final_valid", 128'(data_out_valid), 128'(1'b0));
    chk("final_count", 128'(count), 128'(3'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
